// File: rtl/riscv_dmem_arb.sv
// Two-port data-memory arbiter: round-robin grant onto a single shared bus,
// with misalignment screening and a bus-response watchdog.
module riscv_dmem_arb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 rst_ni,
  input  logic                 clk_i,
  input  logic [1:0]           req_i,
  input  logic [1:0][XLEN-1:0] adr_i,
  input  logic [1:0]           we_i,
  input  logic [1:0][1:0]      size_i,
  input  logic [1:0][XLEN-1:0] d_i,
  output logic [1:0][XLEN-1:0] q_o,
  output logic [1:0]           ack_o,
  output logic [1:0]           err_o,
  output logic [1:0]           misaligned_o,
  output logic                 bus_req_o,
  output logic [XLEN-1:0]      bus_adr_o,
  output logic                 bus_we_o,
  output logic [1:0]           bus_size_o,
  output logic [XLEN-1:0]      bus_d_o,
  input  logic [XLEN-1:0]      bus_q_i,
  input  logic                 bus_ack_i,
  input  logic                 bus_err_i
);

  localparam int unsigned WdW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StMisa} state_e;

  state_e           r_state;
  logic             r_last;       // port granted most recently
  logic             r_misa_port;
  logic [WdW-1:0]   r_wdog;
  logic             r_bus_req;
  logic [XLEN-1:0]  r_bus_adr;
  logic             r_bus_we;
  logic [1:0]       r_bus_size;
  logic [XLEN-1:0]  r_bus_d;

  logic             w_win;
  logic [1:0]       w_size;
  logic [1:0]       w_adr_lo;
  logic             w_misa;
  logic             w_gnt;
  logic             w_port;
  logic             w_timeout;
  logic             w_ack_ev;
  logic             w_err_ev;
  logic             w_done;

  assign w_win    = (req_i == 2'b11) ? ~r_last : req_i[1];
  assign w_size   = size_i[w_win];
  assign w_adr_lo = adr_i[w_win][1:0];

  always_comb begin
    w_misa = 1'b0;
    case (w_size)
      2'd0:    w_misa = 1'b0;
      2'd1:    w_misa = w_adr_lo[0];
      2'd2:    w_misa = |w_adr_lo;
      default: w_misa = 1'b1;
    endcase
  end

  assign w_gnt  = (r_state == StGnt0) || (r_state == StGnt1);
  assign w_port = (r_state == StGnt1);

  // Fires once the counter has reached TIMEOUT, i.e. after TIMEOUT full GNT cycles.
  assign w_timeout = (TIMEOUT != 0) && (r_wdog == WdW'(TIMEOUT));
  assign w_ack_ev  = bus_ack_i & ~bus_err_i;
  assign w_err_ev  = bus_err_i | (w_timeout & ~bus_ack_i);
  assign w_done    = w_gnt & (bus_ack_i | bus_err_i | w_timeout);

  // Responses are dropped if the requester abandoned its request mid-transaction.
  always_comb begin
    ack_o        = '0;
    err_o        = '0;
    misaligned_o = '0;
    q_o          = '0;
    if (w_gnt && req_i[w_port]) begin
      ack_o[w_port] = w_ack_ev;
      err_o[w_port] = w_err_ev;
      if (w_ack_ev) q_o[w_port] = bus_q_i;
    end
    if (r_state == StMisa) misaligned_o[r_misa_port] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_misa_port <= 1'b0;
      r_wdog      <= '0;
      r_bus_req   <= 1'b0;
      r_bus_adr   <= '0;
      r_bus_we    <= 1'b0;
      r_bus_size  <= '0;
      r_bus_d     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|req_i) begin
            if (w_misa) begin
              r_state     <= StMisa;
              r_misa_port <= w_win;
            end else begin
              r_state    <= w_win ? StGnt1 : StGnt0;
              r_last     <= w_win;
              r_wdog     <= '0;
              r_bus_req  <= 1'b1;
              r_bus_adr  <= adr_i[w_win];
              r_bus_we   <= we_i[w_win];
              r_bus_size <= size_i[w_win];
              r_bus_d    <= d_i[w_win];
            end
          end
        end
        StGnt0, StGnt1: begin
          if (w_done) begin
            r_state   <= StIdle;
            r_bus_req <= 1'b0;
          end else if (TIMEOUT != 0) begin
            r_wdog <= r_wdog + WdW'(1);
          end
        end
        StMisa:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_req_o  = r_bus_req;
  assign bus_adr_o  = r_bus_adr;
  assign bus_we_o   = r_bus_we;
  assign bus_size_o = r_bus_size;
  assign bus_d_o    = r_bus_d;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Directed bench for riscv_dmem_arb: load, contention, misalignment, watchdog,
// error priority, abandoned request and mid-transaction reset.
module tb_riscv_dmem_arb;
  localparam int unsigned XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           req = '0;
  logic [1:0][XLEN-1:0] adr = '0;
  logic [1:0]           we = '0;
  logic [1:0][1:0]      size = '0;
  logic [1:0][XLEN-1:0] d = '0;
  logic [1:0][XLEN-1:0] q;
  logic [1:0]           ack, err, misa;
  logic                 bus_req, bus_we;
  logic [XLEN-1:0]      bus_adr, bus_d;
  logic [1:0]           bus_size;
  logic [XLEN-1:0]      bus_q = '0;
  logic                 bus_ack = 1'b0;
  logic                 bus_err = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  riscv_dmem_arb #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .rst_ni       (rst_n),
    .clk_i        (clk),
    .req_i        (req),
    .adr_i        (adr),
    .we_i         (we),
    .size_i       (size),
    .d_i          (d),
    .q_o          (q),
    .ack_o        (ack),
    .err_o        (err),
    .misaligned_o (misa),
    .bus_req_o    (bus_req),
    .bus_adr_o    (bus_adr),
    .bus_we_o     (bus_we),
    .bus_size_o   (bus_size),
    .bus_d_o      (bus_d),
    .bus_q_i      (bus_q),
    .bus_ack_i    (bus_ack),
    .bus_err_i    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int unsigned mv_port [4] = '{1, 0, 0, 1};
  int unsigned mv_size [4] = '{1, 2, 2, 3};
  int unsigned mv_adr  [4] = '{32'h101, 32'h102, 32'h001, 32'h000};

  initial begin
    int exp_p;
    int n_ack0;
    int n_ack1;

    // Reset state
    tick; tick;
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_adr", bus_adr, 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_pulses", {26'h0, ack, err, misa}, 32'h0);
    rst_n = 1'b1;
    tick;

    // Single load, bus ack two cycles after bus_req rises
    req = 2'b01; adr[0] = 32'h100; size[0] = 2'd2; we[0] = 1'b0;
    tick;
    check("ld_bus_req", 32'(bus_req), 32'h1);
    check("ld_bus_adr", bus_adr, 32'h100);
    check("ld_bus_size", 32'(bus_size), 32'h2);
    tick;
    check("ld_no_early_ack", 32'(ack), 32'h0);
    tick;
    bus_ack = 1'b1; bus_q = 32'hDEADBEEF;
    #2;
    check("ld_ack", 32'(ack), 32'h1);
    check("ld_q0", q[0], 32'hDEADBEEF);
    check("ld_q1_zero", q[1], 32'h0);
    tick;
    bus_ack = 1'b0; req = 2'b00;
    #2;
    check("ld_bus_req_drop", 32'(bus_req), 32'h0);
    tick;

    // Contention: port 0 was granted last, so port 1 goes first
    adr[0] = 32'h200; size[0] = 2'd2; we[0] = 1'b0; d[0] = 32'h11111111;
    adr[1] = 32'h300; size[1] = 2'd2; we[1] = 1'b1; d[1] = 32'hCAFEF00D;
    req = 2'b11;
    exp_p = 1; n_ack0 = 0; n_ack1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_bus_adr", bus_adr, exp_p ? 32'h300 : 32'h200);
      check("rr_bus_we", 32'(bus_we), 32'(exp_p));
      check("rr_bus_d", bus_d, exp_p ? 32'hCAFEF00D : 32'h11111111);
      bus_ack = 1'b1; bus_q = 32'h1000 + 32'(i);
      #2;
      check("rr_ack", 32'(ack), exp_p ? 32'h2 : 32'h1);
      check("rr_q", q[exp_p], 32'h1000 + 32'(i));
      n_ack0 += int'(ack[0]);
      n_ack1 += int'(ack[1]);
      tick;
      bus_ack = 1'b0;
      #2;
      check("rr_gap", 32'(bus_req), 32'h0);
      exp_p = 1 - exp_p;
    end
    check("rr_acks0", 32'(n_ack0), 32'h2);
    check("rr_acks1", 32'(n_ack1), 32'h2);
    req = 2'b00; we = '0;
    tick;

    // Misaligned requests never reach the bus
    for (int i = 0; i < 4; i++) begin
      adr[mv_port[i]]  = mv_adr[i];
      size[mv_port[i]] = 2'(mv_size[i]);
      req = 2'(1 << mv_port[i]);
      tick;
      check("misa_pulse", 32'(misa), 32'(1 << mv_port[i]));
      check("misa_no_bus", 32'(bus_req), 32'h0);
      check("misa_no_ack", {30'h0, ack | err}, 32'h0);
      req = 2'b00;
      tick;
      check("misa_one_cycle", 32'(misa), 32'h0);
    end

    // Watchdog: error after four full GNT0 cycles with no response
    adr[0] = 32'h400; size[0] = 2'd2; req = 2'b01;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("wd_waiting_req", 32'(bus_req), 32'h1);
      check("wd_waiting_err", 32'(err), 32'h0);
      tick;
    end
    check("wd_err", 32'(err), 32'h1);
    req = 2'b00;
    tick;
    check("wd_bus_req_drop", 32'(bus_req), 32'h0);
    req = 2'b01;
    tick;
    check("wd_reserve_req", 32'(bus_req), 32'h1);
    bus_ack = 1'b1; bus_q = 32'h5A5A5A5A;
    #2;
    check("wd_reserve_ack", 32'(ack), 32'h1);
    check("wd_reserve_q", q[0], 32'h5A5A5A5A);
    tick;
    bus_ack = 1'b0; req = 2'b00;
    tick;

    // Error wins over a simultaneous ack
    adr[1] = 32'h500; size[1] = 2'd2; req = 2'b10;
    tick;
    bus_ack = 1'b1; bus_err = 1'b1; bus_q = 32'hFFFF0000;
    #2;
    check("prio_err", 32'(err), 32'h2);
    check("prio_ack", 32'(ack), 32'h0);
    check("prio_q", q[1], 32'h0);
    tick;
    req = 2'b00;
    #2;
    check("prio_drop", 32'(bus_req), 32'h0);
    check("idle_resp_ignored", {30'h0, ack | err}, 32'h0);
    bus_ack = 1'b0; bus_err = 1'b0;
    tick;

    // Abandoned request: bus completes, response discarded
    adr[0] = 32'h600; size[0] = 2'd0; req = 2'b01;
    tick;
    req = 2'b00; bus_ack = 1'b1; bus_q = 32'h12345678;
    #2;
    check("abandon_ack", 32'(ack), 32'h0);
    check("abandon_q", q[0], 32'h0);
    tick;
    bus_ack = 1'b0;
    check("abandon_drop", 32'(bus_req), 32'h0);
    tick;

    // Reset during GNT1 aborts; afterwards port 0 wins first
    adr[1] = 32'h700; size[1] = 2'd2; req = 2'b10;
    tick;
    check("mid_gnt1", 32'(bus_req), 32'h1);
    rst_n = 1'b0; bus_ack = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(bus_req), 32'h0);
    check("mid_rst_pulses", {26'h0, ack, err, misa}, 32'h0);
    bus_ack = 1'b0; req = 2'b11;
    tick;
    rst_n = 1'b1;
    tick;
    check("post_rst_req", 32'(bus_req), 32'h1);
    check("post_rst_port0", bus_adr, 32'h600);
    bus_ack = 1'b1; bus_q = 32'h0BADF00D;
    #2;
    check("post_rst_ack", 32'(ack), 32'h1);
    tick;
    bus_ack = 1'b0; req = 2'b00;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
